// File: rtl/ex_arb_pkg.sv
// Shared types and defaults for the ex bus arbiter: FSM state encoding,
// default parameter values and the grant-id width helper.
package ex_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_GAP_CC    = 0;

  // Width of a requester index; never narrower than one bit.
  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ex_rr_picker.sv
// Combinational round-robin selector: returns the first valid requester
// found searching upward from last_grant+1, wrapping modulo NUM_REQ.
module ex_rr_picker
  import ex_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = gid_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ex_bus_arbiter.sv
// Round-robin arbiter sharing one registered data/valid bus among NUM_REQ
// valid/ready requesters, with bounded bursts and an optional idle gap.
module ex_bus_arbiter
  import ex_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int GAP_CC    = DEF_GAP_CC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_valid,
  output logic [gid_w(NUM_REQ)-1:0] o_grant_id,
  output logic                      o_busy
);

  localparam int ID_W = gid_w(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);
  localparam logic [3:0]      GAP_LAST   = 4'(GAP_CC - 1);
  localparam logic [ID_W-1:0] LAST_INIT  = ID_W'(NUM_REQ - 1);

  state_t          state, state_nx;
  logic [ID_W-1:0] grant, grant_nx;
  logic [ID_W-1:0] last_grant, last_grant_nx;
  logic [BC_W-1:0] burst_cnt, burst_cnt_nx;
  logic [3:0]      gap_cnt, gap_cnt_nx;
  logic            burst_end;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [ID_W-1:0]   gid_p1;

  ex_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .valid      (i_req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Stage p0: beat accepted from the granted requester this cycle
  assign vld_p0  = (state == ST_BURST) && i_req_valid[grant];
  assign data_p0 = i_req_data[int'(grant)*DATA_W +: DATA_W];

  // Ready is a pure decode of registered state, so valid never loops into ready.
  always_comb begin
    o_req_ready = '0;
    if (state == ST_BURST) begin
      o_req_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    burst_cnt_nx  = burst_cnt;
    gap_cnt_nx    = gap_cnt;
    burst_end     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nx     = pick_idx;
          burst_cnt_nx = '0;
          state_nx     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (vld_p0) begin
          burst_cnt_nx = burst_cnt + 1'b1;
          burst_end    = (burst_cnt == BURST_LAST);
        end else begin
          burst_end = 1'b1;
        end
        if (burst_end) begin
          last_grant_nx = grant;
          gap_cnt_nx    = '0;
          state_nx      = (GAP_CC > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = ST_IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + 4'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_INIT;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      burst_cnt  <= burst_cnt_nx;
      gap_cnt    <= gap_cnt_nx;
    end
  end

  // Stage p0 -> p1: registered shared bus; data and id hold between beats
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      gid_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        data_p1 <= data_p0;
        gid_p1  <= grant;
      end
    end
  end

  assign o_valid    = vld_p1;
  assign o_data     = data_p1;
  assign o_grant_id = gid_p1;
  assign o_busy     = (state != ST_IDLE);

endmodule
